// File: rtl/codec_i2c_access_sequencer.sv
// -----------------------------------------------------------------------------
// codec_i2c_access_sequencer
//
// Turns one codec register-access request (write or read flag, 7-bit register
// address, 9-bit register value) into the byte-level command stream that the
// I2C byte engine needs to reach the SSM2603. It hands read-back data and
// status (busy, missed ACK) back to the register file. It also pulses a clear
// strobe when the request is finished.
//
// Ports
//   s00_axi_aclk / s00_axi_aresetn  clock, asynchronous active-low reset
//   controller_reset                synchronous soft reset (active high)
//   codec_i2c_data_wr/_rd           level request flags from the register file
//   codec_i2c_addr, _wr_data        register address [6:0], register value [8:0]
//   clear_codec_i2c_data_wr/_rd     1-cycle "request finished" pulses
//   codec_i2c_rd_data, update_*     read-back value and its 1-cycle valid pulse
//   controller_busy, missed_ack     status (missed_ack is sticky per transaction)
//   cmd_valid/cmd_ready/cmd_op/cmd_wdata   command channel to the byte engine
//   rsp_valid/rsp_nack/rsp_rdata           response channel from the byte engine
// -----------------------------------------------------------------------------
module codec_i2c_access_sequencer #(
  parameter logic [6:0]  DEVICE_ADDR    = 7'h1A,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        s00_axi_aclk,
  input  logic        s00_axi_aresetn,
  input  logic        controller_reset,
  input  logic        codec_i2c_data_wr,
  input  logic        codec_i2c_data_rd,
  input  logic [31:0] codec_i2c_addr,
  input  logic [31:0] codec_i2c_wr_data,
  output logic        clear_codec_i2c_data_wr,
  output logic        clear_codec_i2c_data_rd,
  output logic [31:0] codec_i2c_rd_data,
  output logic        update_codec_i2c_rd_data,
  output logic        controller_busy,
  output logic        missed_ack,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_op,
  output logic [7:0]  cmd_wdata,
  input  logic        rsp_valid,
  input  logic        rsp_nack,
  input  logic [7:0]  rsp_rdata
);

  localparam int unsigned    TW           = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    OP_START     = 3'd0,
    OP_WRITE     = 3'd1,
    OP_READ_ACK  = 3'd2,
    OP_READ_NACK = 3'd3,
    OP_STOP      = 3'd4,
    OP_RSTART    = 3'd5
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_ABORT, S_WAIT_STOP, S_DONE
  } state_t;

  typedef struct packed {
    op_t        op;
    logic [7:0] wdata;
  } cmd_t;

  localparam cmd_t CMD_START = '{op: OP_START, wdata: 8'h00};
  localparam cmd_t CMD_STOP  = '{op: OP_STOP,  wdata: 8'h00};

  // Command for a given step of the write or read sequence. The last step of
  // both sequences is STOP, which is also what any step past the end yields.
  function automatic cmd_t seq_cmd(input logic       is_rd,
                                   input logic [2:0] step,
                                   input logic [6:0] addr,
                                   input logic [8:0] data);
    cmd_t c;
    // NOTE: default first so every path through the case assigns c (no latch).
    c = CMD_STOP;
    if (!is_rd) begin
      case (step)
        3'd0:    c = CMD_START;
        3'd1:    c = '{op: OP_WRITE, wdata: {DEVICE_ADDR, 1'b0}};
        3'd2:    c = '{op: OP_WRITE, wdata: {addr, data[8]}};
        3'd3:    c = '{op: OP_WRITE, wdata: data[7:0]};
        default: c = CMD_STOP;
      endcase
    end else begin
      case (step)
        3'd0:    c = CMD_START;
        3'd1:    c = '{op: OP_WRITE,     wdata: {DEVICE_ADDR, 1'b0}};
        3'd2:    c = '{op: OP_WRITE,     wdata: {addr, 1'b0}};
        3'd3:    c = '{op: OP_RSTART,    wdata: 8'h00};
        3'd4:    c = '{op: OP_WRITE,     wdata: {DEVICE_ADDR, 1'b1}};
        3'd5:    c = '{op: OP_READ_ACK,  wdata: 8'h00};
        3'd6:    c = '{op: OP_READ_NACK, wdata: 8'h00};
        default: c = CMD_STOP;
      endcase
    end
    return c;
  endfunction

  state_t          r_state;
  logic [2:0]      r_step;
  logic [TW-1:0]   r_timer;
  logic            r_is_rd;
  logic [6:0]      r_addr;
  logic [8:0]      r_data;
  logic            r_rd_hi;
  logic [7:0]      r_rd_lo;
  logic [8:0]      r_rd_data;
  logic            r_idle_wait;   // forces one idle cycle after DONE before sampling flags
  logic            r_busy;
  logic            r_missed_ack;
  logic            r_clear_wr;
  logic            r_clear_rd;
  logic            r_update;
  logic            r_cmd_valid;
  cmd_t            r_cmd;

  // Upper address/data bits are don't-care for this codec.
  logic w_unused;
  assign w_unused = ^{codec_i2c_addr[31:7], codec_i2c_wr_data[31:9]};

  // NOTE: all sequential state below uses non-blocking assignments only.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state      <= S_IDLE;
      r_step       <= '0;
      r_timer      <= '0;
      r_is_rd      <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_rd_hi      <= 1'b0;
      r_rd_lo      <= '0;
      r_rd_data    <= '0;
      r_idle_wait  <= 1'b0;
      r_busy       <= 1'b0;
      r_missed_ack <= 1'b0;
      r_clear_wr   <= 1'b0;
      r_clear_rd   <= 1'b0;
      r_update     <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd        <= CMD_START;
    end else if (controller_reset) begin
      // Soft reset drops everything at once; no STOP is sent to the bus.
      r_state      <= S_IDLE;
      r_step       <= '0;
      r_timer      <= '0;
      r_is_rd      <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_rd_hi      <= 1'b0;
      r_rd_lo      <= '0;
      r_rd_data    <= '0;
      r_idle_wait  <= 1'b0;
      r_busy       <= 1'b0;
      r_missed_ack <= 1'b0;
      r_clear_wr   <= 1'b0;
      r_clear_rd   <= 1'b0;
      r_update     <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd        <= CMD_START;
    end else begin
      r_clear_wr <= 1'b0;
      r_clear_rd <= 1'b0;
      r_update   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (r_idle_wait) begin
            r_idle_wait <= 1'b0;
          end else if (codec_i2c_data_wr || codec_i2c_data_rd) begin
            r_is_rd      <= !codec_i2c_data_wr;   // write wins a tie
            r_addr       <= codec_i2c_addr[6:0];
            r_data       <= codec_i2c_wr_data[8:0];
            r_missed_ack <= 1'b0;
            r_busy       <= 1'b1;
            r_step       <= '0;
            r_cmd        <= CMD_START;
            r_cmd_valid  <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_timer     <= '0;
            r_state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (rsp_valid) begin
            if (r_cmd.op == OP_WRITE && rsp_nack) begin
              r_missed_ack <= 1'b1;
              r_cmd        <= CMD_STOP;
              r_cmd_valid  <= 1'b1;
              r_state      <= S_ABORT;
            end else if (r_cmd.op == OP_STOP) begin
              r_clear_wr <= !r_is_rd;
              r_clear_rd <= r_is_rd;
              if (r_is_rd) begin
                r_rd_data <= {r_rd_hi, r_rd_lo};
                r_update  <= 1'b1;
              end
              r_state <= S_DONE;
            end else begin
              if (r_cmd.op == OP_READ_ACK)  r_rd_hi <= rsp_rdata[0];
              if (r_cmd.op == OP_READ_NACK) r_rd_lo <= rsp_rdata;
              r_step      <= r_step + 3'd1;
              r_cmd       <= seq_cmd(r_is_rd, r_step + 3'd1, r_addr, r_data);
              r_cmd_valid <= 1'b1;
              r_state     <= S_ISSUE;
            end
          end else if (r_timer == TIMEOUT_LAST) begin
            r_missed_ack <= 1'b1;
            r_cmd        <= CMD_STOP;
            r_cmd_valid  <= 1'b1;
            r_state      <= S_ABORT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_ABORT: begin
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_timer     <= '0;
            r_state     <= S_WAIT_STOP;
          end
        end

        // The abort STOP gets one timeout window; after that we finish anyway.
        // An aborted read never touches the read-back register.
        S_WAIT_STOP: begin
          if (rsp_valid || r_timer == TIMEOUT_LAST) begin
            r_clear_wr <= !r_is_rd;
            r_clear_rd <= r_is_rd;
            r_state    <= S_DONE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_DONE: begin
          r_busy      <= 1'b0;
          r_idle_wait <= 1'b1;
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign clear_codec_i2c_data_wr  = r_clear_wr;
  assign clear_codec_i2c_data_rd  = r_clear_rd;
  assign codec_i2c_rd_data        = {23'b0, r_rd_data};
  assign update_codec_i2c_rd_data = r_update;
  assign controller_busy          = r_busy;
  assign missed_ack               = r_missed_ack;
  assign cmd_valid                = r_cmd_valid;
  assign cmd_op                   = r_cmd.op;
  assign cmd_wdata                = r_cmd.wdata;

endmodule

// File: tb/tb_codec_i2c_access_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for codec_i2c_access_sequencer. A small byte-engine model answers each
// command one cycle after acceptance, can stall cmd_ready, NACK a chosen
// command or stay silent. It logs every accepted command. The register-file
// model keeps a request flag high for two cycles after its clear pulse.
// -----------------------------------------------------------------------------
module tb_codec_i2c_access_sequencer;

  localparam logic [2:0] OP_START = 3'd0, OP_WRITE = 3'd1, OP_RACK = 3'd2,
                         OP_RNACK = 3'd3, OP_STOP = 3'd4, OP_RSTART = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        controller_reset = 1'b0;
  logic        codec_i2c_data_wr = 1'b0;
  logic        codec_i2c_data_rd = 1'b0;
  logic [31:0] codec_i2c_addr = '0;
  logic [31:0] codec_i2c_wr_data = '0;
  logic        clear_wr, clear_rd, update_rd, controller_busy, missed_ack;
  logic [31:0] rd_data;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid = 1'b0;
  logic        rsp_nack = 1'b0;
  logic [7:0]  rsp_rdata = '0;

  codec_i2c_access_sequencer #(.DEVICE_ADDR(7'h1A), .TIMEOUT_CYCLES(16)) dut (
    .s00_axi_aclk             (clk),
    .s00_axi_aresetn          (rst_n),
    .controller_reset         (controller_reset),
    .codec_i2c_data_wr        (codec_i2c_data_wr),
    .codec_i2c_data_rd        (codec_i2c_data_rd),
    .codec_i2c_addr           (codec_i2c_addr),
    .codec_i2c_wr_data        (codec_i2c_wr_data),
    .clear_codec_i2c_data_wr  (clear_wr),
    .clear_codec_i2c_data_rd  (clear_rd),
    .codec_i2c_rd_data        (rd_data),
    .update_codec_i2c_rd_data (update_rd),
    .controller_busy          (controller_busy),
    .missed_ack               (missed_ack),
    .cmd_valid                (cmd_valid),
    .cmd_ready                (cmd_ready),
    .cmd_op                   (cmd_op),
    .cmd_wdata                (cmd_wdata),
    .rsp_valid                (rsp_valid),
    .rsp_nack                 (rsp_nack),
    .rsp_rdata                (rsp_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- engine model + output monitor (negedge) ----------------
  logic [10:0] log_q[$];
  int          stamp_q[$];
  int          tick = 0;
  logic        pend = 1'b0;
  logic        pend_nack = 1'b0;
  logic [7:0]  pend_rdata = '0;
  logic        rsp_en = 1'b1;      // configured by the stimulus block
  int          nack_at = -1;
  logic [7:0]  rd_hi = '0, rd_lo = '0;
  int          stall_req = 0;
  int          stall_used = 0;
  logic        stall_seen = 1'b0;
  logic [10:0] stall_cmd = '0;
  int          n_unstable = 0;
  int          n_overlap = 0;      // cmd_valid while a response is still owed
  int          n_clr_wr = 0, n_clr_rd = 0, n_upd = 0, n_upd_clr = 0;

  always @(negedge clk) begin
    tick++;
    if (clear_wr)  n_clr_wr++;
    if (clear_rd)  n_clr_rd++;
    if (update_rd) begin
      n_upd++;
      if (clear_rd) n_upd_clr++;
    end
    if (cmd_valid && pend) n_overlap++;
    rsp_valid = 1'b0;
    rsp_nack  = 1'b0;
    rsp_rdata = '0;
    if (pend) begin
      rsp_valid = 1'b1;
      rsp_nack  = pend_nack;
      rsp_rdata = pend_rdata;
      pend      = 1'b0;
    end
    if (cmd_valid) begin
      if (stall_used < stall_req) begin
        cmd_ready = 1'b0;
        if (!stall_seen) begin
          stall_seen = 1'b1;
          stall_cmd  = {cmd_op, cmd_wdata};
        end else if ({cmd_op, cmd_wdata} != stall_cmd) begin
          n_unstable++;
        end
        stall_used++;
      end else begin
        cmd_ready  = 1'b1;
        stall_seen = 1'b0;
        log_q.push_back({cmd_op, cmd_wdata});
        stamp_q.push_back(tick);
        if (rsp_en) begin
          pend       = 1'b1;
          pend_nack  = (log_q.size() - 1 == nack_at);
          pend_rdata = (cmd_op == OP_RACK) ? rd_hi : (cmd_op == OP_RNACK) ? rd_lo : 8'h00;
        end
      end
    end else begin
      cmd_ready = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick1();
    @(negedge clk);
    #1;
  endtask

  // Raise request flag(s), then behave like the register file: each flag is
  // dropped two cycles after its clear pulse. Bounded waits count as checks.
  task automatic run_txn(input string tag, input logic wr, input logic rd,
                         input logic [31:0] addr, input logic [31:0] data,
                         output logic missed_at_accept);
    int budget;
    int wr_hold;
    int rd_hold;
    codec_i2c_addr    = addr;
    codec_i2c_wr_data = data;
    codec_i2c_data_wr = wr;
    codec_i2c_data_rd = rd;
    budget = 0;
    while (!controller_busy && budget < 20) begin
      tick1();
      budget++;
    end
    check({tag, "_accept"}, {31'b0, controller_busy}, 32'd1);
    missed_at_accept = missed_ack;
    wr_hold = 0;
    rd_hold = 0;
    budget  = 0;
    while ((codec_i2c_data_wr || codec_i2c_data_rd) && budget < 400) begin
      tick1();
      budget++;
      if (wr_hold > 0) begin
        wr_hold--;
        if (wr_hold == 0) codec_i2c_data_wr = 1'b0;
      end
      if (rd_hold > 0) begin
        rd_hold--;
        if (rd_hold == 0) codec_i2c_data_rd = 1'b0;
      end
      if (clear_wr && codec_i2c_data_wr) wr_hold = 2;
      if (clear_rd && codec_i2c_data_rd) rd_hold = 2;
    end
    check({tag, "_flags_cleared"}, {31'b0, codec_i2c_data_wr | codec_i2c_data_rd}, 32'd0);
    budget = 0;
    while (controller_busy && budget < 100) begin
      tick1();
      budget++;
    end
    repeat (5) tick1();
    check({tag, "_idle"}, {31'b0, controller_busy}, 32'd0);
  endtask

  // Compare the commands accepted since 'base' with the expected list.
  // Only WRITE carries a meaningful data byte.
  task automatic check_log(input string tag, input int base, input logic [10:0] exp[$]);
    logic [10:0] a;
    check({tag, "_ncmd"}, log_q.size() - base, exp.size());
    for (int i = 0; i < exp.size() && base + i < log_q.size(); i++) begin
      a = log_q[base + i];
      if (a[10:8] != OP_WRITE) a[7:0] = 8'h00;
      check($sformatf("%s_cmd%0d", tag, i), {21'b0, a}, {21'b0, exp[i]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          budget;
    int          clr_wr0, clr_rd0, upd0, upd_clr0, stall0;
    logic        m;
    logic [10:0] exp_q[$];

    // ---------------- reset ----------------
    repeat (3) tick1();
    rst_n = 1'b1;
    tick1();
    check("rst_busy",      {31'b0, controller_busy}, 32'd0);
    check("rst_missed",    {31'b0, missed_ack},      32'd0);
    check("rst_cmd_valid", {31'b0, cmd_valid},       32'd0);
    check("rst_rd_data",   rd_data,                  32'd0);
    check("rst_pulses",    {29'b0, clear_wr, clear_rd, update_rd}, 32'd0);

    // ---------------- controller_reset during read step 5 ----------------
    rd_hi = 8'h01; rd_lo = 8'h5A;
    base = log_q.size();
    clr_rd0 = n_clr_rd; upd0 = n_upd;
    codec_i2c_addr    = 32'h4;
    codec_i2c_data_rd = 1'b1;
    budget = 0;
    while (log_q.size() < base + 6 && budget < 100) begin
      tick1();
      budget++;
    end
    check("crst_reached_step5", log_q.size() - base, 32'd6);
    controller_reset  = 1'b1;
    codec_i2c_data_rd = 1'b0;
    tick1();
    check("crst_busy",      {31'b0, controller_busy}, 32'd0);
    check("crst_cmd_valid", {31'b0, cmd_valid},       32'd0);
    check("crst_rd_data",   rd_data,                  32'd0);
    controller_reset = 1'b0;
    repeat (6) tick1();
    check("crst_no_stop",    log_q.size() - base, 32'd6);
    check("crst_no_clear",   n_clr_rd - clr_rd0,  32'd0);
    check("crst_no_update",  n_upd - upd0,        32'd0);

    // ---------------- write 0x06 <= 0x1F0 ----------------
    base = log_q.size();
    clr_wr0 = n_clr_wr; clr_rd0 = n_clr_rd; upd0 = n_upd;
    run_txn("wr", 1'b1, 1'b0, 32'h6, 32'h1F0, m);
    exp_q = '{{OP_START, 8'h00}, {OP_WRITE, 8'h34}, {OP_WRITE, 8'h0D},
              {OP_WRITE, 8'hF0}, {OP_STOP, 8'h00}};
    check_log("wr", base, exp_q);
    check("wr_clear_wr", n_clr_wr - clr_wr0, 32'd1);
    check("wr_clear_rd", n_clr_rd - clr_rd0, 32'd0);
    check("wr_update",   n_upd - upd0,       32'd0);
    check("wr_missed",   {31'b0, missed_ack}, 32'd0);

    // ---------------- read 0x04 -> 0x15A ----------------
    base = log_q.size();
    clr_wr0 = n_clr_wr; clr_rd0 = n_clr_rd; upd0 = n_upd; upd_clr0 = n_upd_clr;
    run_txn("rd", 1'b0, 1'b1, 32'h4, 32'h0, m);
    exp_q = '{{OP_START, 8'h00}, {OP_WRITE, 8'h34}, {OP_WRITE, 8'h08},
              {OP_RSTART, 8'h00}, {OP_WRITE, 8'h35}, {OP_RACK, 8'h00},
              {OP_RNACK, 8'h00}, {OP_STOP, 8'h00}};
    check_log("rd", base, exp_q);
    check("rd_data",       rd_data,                 32'h0000015A);
    check("rd_clear_rd",   n_clr_rd - clr_rd0,      32'd1);
    check("rd_clear_wr",   n_clr_wr - clr_wr0,      32'd0);
    check("rd_update",     n_upd - upd0,            32'd1);
    check("rd_upd_w_clr",  n_upd_clr - upd_clr0,    32'd1);
    check("rd_missed",     {31'b0, missed_ack},     32'd0);

    // ---------------- NACK on device address of a write ----------------
    base = log_q.size();
    clr_wr0 = n_clr_wr; upd0 = n_upd;
    nack_at = base + 1;
    run_txn("nack", 1'b1, 1'b0, 32'h6, 32'h1F0, m);
    nack_at = -1;
    exp_q = '{{OP_START, 8'h00}, {OP_WRITE, 8'h34}, {OP_STOP, 8'h00}};
    check_log("nack", base, exp_q);
    check("nack_missed",   {31'b0, missed_ack}, 32'd1);
    check("nack_clear_wr", n_clr_wr - clr_wr0,  32'd1);
    check("nack_update",   n_upd - upd0,        32'd0);
    check("nack_rd_data",  rd_data,             32'h0000015A);

    // ---------------- silent engine: timeout, abort, second timeout ----------------
    base = log_q.size();
    clr_wr0 = n_clr_wr;
    rsp_en = 1'b0;
    run_txn("tmo", 1'b1, 1'b0, 32'h6, 32'h1F0, m);
    rsp_en = 1'b1;
    check("tmo_missed_cleared_on_accept", {31'b0, m}, 32'd0);
    exp_q = '{{OP_START, 8'h00}, {OP_STOP, 8'h00}};
    check_log("tmo", base, exp_q);
    if (log_q.size() >= base + 2)
      check("tmo_wait_cycles", stamp_q[base + 1] - stamp_q[base], 32'd17);
    check("tmo_missed",   {31'b0, missed_ack}, 32'd1);
    check("tmo_clear_wr", n_clr_wr - clr_wr0,  32'd1);

    // ---------------- wr+rd together, first command stalled 5 cycles ----------------
    base = log_q.size();
    clr_wr0 = n_clr_wr; clr_rd0 = n_clr_rd; upd0 = n_upd;
    rd_hi = 8'hFE; rd_lo = 8'hA5;
    stall0 = stall_used;
    stall_req = stall_used + 5;
    run_txn("both", 1'b1, 1'b1, 32'hFFFF_FF89, 32'h0000_00AB, m);
    check("both_missed_cleared_on_accept", {31'b0, m}, 32'd0);
    check("both_stall_cycles", stall_used - stall0, 32'd5);
    check("both_stable",       n_unstable,          32'd0);
    exp_q = '{{OP_START, 8'h00}, {OP_WRITE, 8'h34}, {OP_WRITE, 8'h12},
              {OP_WRITE, 8'hAB}, {OP_STOP, 8'h00},
              {OP_START, 8'h00}, {OP_WRITE, 8'h34}, {OP_WRITE, 8'h12},
              {OP_RSTART, 8'h00}, {OP_WRITE, 8'h35}, {OP_RACK, 8'h00},
              {OP_RNACK, 8'h00}, {OP_STOP, 8'h00}};
    check_log("both", base, exp_q);
    check("both_clear_wr", n_clr_wr - clr_wr0, 32'd1);
    check("both_clear_rd", n_clr_rd - clr_rd0, 32'd1);
    check("both_update",   n_upd - upd0,       32'd1);
    check("both_rd_data",  rd_data,            32'h000000A5);

    check("one_cmd_outstanding", n_overlap, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
